// File: rtl/mem_access_unit_if.sv
// ----------------------------------------------------------------------------
// mem_access_unit_if: control-side request bus plus memory-side port.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  modport slave (
    input  req, we, funct3, addr, wdata, m_ack, m_rdata,
    output rdata, done, busy, err, m_req, m_we, m_be, m_addr, m_wdata
  );

  modport master (
    output req, we, funct3, addr, wdata, m_ack, m_rdata,
    input  rdata, done, busy, err, m_req, m_we, m_be, m_addr, m_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit: load/store stage driving a variable-latency memory port.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned halves/words.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [3:0]  m_be_q, m_be_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;

  logic        legal;
  logic        misaligned;
  logic        trap;
  logic [1:0]  off_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_lanes;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Request decode from the live control-side inputs (used only in IDLE).
  always_comb begin
    legal       = 1'b0;
    misaligned  = 1'b0;
    off_in      = 2'b00;
    be_in       = 4'b1111;
    wdata_lanes = bus.wdata;
    if (bus.we) begin
      legal = !bus.funct3[2] && (bus.funct3[1:0] != 2'b11);
    end else begin
      legal = (bus.funct3[1:0] != 2'b11) && !(bus.funct3[2] && bus.funct3[1]);
    end
    case (bus.funct3[1:0])
      2'b00: begin
        off_in      = bus.addr[1:0];
        be_in       = 4'b0001 << bus.addr[1:0];
        wdata_lanes = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        misaligned  = bus.addr[0];
        off_in      = {bus.addr[1], 1'b0};
        be_in       = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{bus.wdata[15:0]}};
      end
      default: begin
        misaligned  = |bus.addr[1:0];
      end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = misaligned;
`else
  // Misaligned halves/words are silently aligned down by off_in/be_in.
  assign trap = 1'b0;
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
`endif

  // Load extraction from the memory word using the latched width and offset.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = bus.m_rdata[7:0];
      2'd1:    ld_byte = bus.m_rdata[15:8];
      2'd2:    ld_byte = bus.m_rdata[23:16];
      default: ld_byte = bus.m_rdata[31:24];
    endcase
    ld_half = off_q[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = bus.m_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    f3_d      = f3_q;
    off_d     = off_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d   = bus.we;
          f3_d   = bus.funct3;
          off_d  = off_in;
          busy_d = 1'b1;
          if (!legal || trap) begin
            state_d = S_RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d   = S_WAIT;
            cnt_d     = 8'd0;
            m_req_d   = 1'b1;
            m_we_d    = bus.we;
            m_be_d    = be_in;
            m_addr_d  = {bus.addr[31:2], 2'b00};
            m_wdata_d = wdata_lanes;
          end
        end
      end
      S_WAIT: begin
        if (bus.m_ack) begin
          state_d = S_RESP;
          done_d  = 1'b1;
          m_req_d = 1'b0;
          if (!we_q) begin
            rdata_d = ld_ext;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          done_d  = 1'b1;
          err_d   = 1'b1;
          m_req_d = 1'b0;
          rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      rdata_q   <= 32'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= 4'd0;
      m_addr_q  <= 32'd0;
      m_wdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;
  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_be    = m_be_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit: directed and randomized checks against a byte-level model.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] exp_rdata;
  logic [3:0]  cap_be;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_we;
  logic        cap_err;
  logic [31:0] cap_rdata;
  int          cap_done_cyc;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Model load: gather nb bytes starting at st, then extend.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input int st, input logic [31:0] mrd);
    int nb;
    logic [31:0] v;
    nb = nbytes(f3);
    v  = 32'd0;
    for (int j = 0; j < nb; j++)
      v |= ((mrd >> (8 * (st + j))) & 32'hFF) << (8 * j);
    if (!f3[2] && nb < 4 && v[8*nb-1])
      v |= ~((32'd1 << (8 * nb)) - 32'd1);
    return v;
  endfunction

  function automatic logic [31:0] model_lanes(input logic [2:0] f3, input logic [31:0] wd);
    int nb;
    logic [31:0] e;
    nb = nbytes(f3);
    e  = 32'd0;
    for (int i = 0; i < 4; i++)
      e[8*i +: 8] = wd[8*(i % nb) +: 8];
    return e;
  endfunction

  task automatic run_txn(input logic t_we, input logic [2:0] t_f3, input logic [31:0] t_addr,
                         input logic [31:0] t_wdata, input int ack_dly, input logic [31:0] t_mrd,
                         input bit noise);
    int   nb, st, k;
    bit   legal, trap, acked;
    logic [3:0] e_be;
    nb    = nbytes(t_f3);
    st    = int'(t_addr[1:0]);
    trap  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap  = (st % nb) != 0;
`endif
    st    = st - (st % nb);
    legal = t_we ? (t_f3 <= 3'd2) : (t_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e_be  = 4'(((1 << nb) - 1) << st);
    cap_be = 4'd0; cap_addr = 32'd0; cap_wdata = 32'd0; cap_we = 1'b0;
    cap_err = 1'b0; cap_rdata = 32'd0; cap_done_cyc = -1;

    bus.req = 1'b1; bus.we = t_we; bus.funct3 = t_f3; bus.addr = t_addr; bus.wdata = t_wdata;
    bus.m_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0; bus.we = 1'($urandom); bus.addr = $urandom; bus.wdata = $urandom;
    if (!legal || trap) begin
      chk("early_done", 32'(bus.done), 32'd1);
      chk("early_err", 32'(bus.err), 32'd1);
      chk("early_mreq", 32'(bus.m_req), 32'd0);
      chk("early_busy", 32'(bus.busy), 32'd1);
      chk("early_rdata", bus.rdata, exp_rdata);
      cap_err = bus.err; cap_rdata = bus.rdata; cap_done_cyc = 1;
    end else begin
      acked = 1'b0;
      for (k = 1; k <= TO && !acked; k++) begin
        chk("wait_mreq", 32'(bus.m_req), 32'd1);
        chk("wait_busy", 32'(bus.busy), 32'd1);
        chk("wait_done", 32'(bus.done), 32'd0);
        if (k == 1) begin
          cap_be = bus.m_be; cap_addr = bus.m_addr; cap_wdata = bus.m_wdata; cap_we = bus.m_we;
          chk("m_be", 32'(bus.m_be), 32'(e_be));
          chk("m_addr", bus.m_addr, t_addr & 32'hFFFF_FFFC);
          chk("m_we", 32'(bus.m_we), 32'(t_we));
          if (t_we) chk("m_wdata", bus.m_wdata, model_lanes(t_f3, t_wdata));
        end
        if (noise) begin
          bus.req = 1'($urandom); bus.funct3 = 3'($urandom); bus.we = 1'($urandom);
        end
        if (k - 1 == ack_dly) begin
          bus.m_ack = 1'b1; bus.m_rdata = t_mrd; acked = 1'b1;
        end else begin
          bus.m_ack = 1'b0; bus.m_rdata = $urandom;
        end
        @(negedge clk);
      end
      // RESP cycle: ack and req here must both be ignored
      bus.m_ack = noise ? 1'($urandom) : 1'b0;
      bus.req   = noise ? 1'($urandom) : 1'b0;
      if (acked) begin
        if (!t_we) exp_rdata = model_load(t_f3, st, t_mrd);
      end else begin
        exp_rdata = 32'd0;
      end
      chk("resp_done", 32'(bus.done), 32'd1);
      chk("resp_err", 32'(bus.err), acked ? 32'd0 : 32'd1);
      chk("resp_rdata", bus.rdata, exp_rdata);
      chk("resp_mreq", 32'(bus.m_req), 32'd0);
      chk("resp_busy", 32'(bus.busy), 32'd1);
      cap_err = bus.err; cap_rdata = bus.rdata; cap_done_cyc = k;
    end
    @(negedge clk);
    bus.req = 1'b0; bus.m_ack = 1'b0;
    chk("post_done", 32'(bus.done), 32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_mreq", 32'(bus.m_req), 32'd0);
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'd0; bus.addr = 32'd0; bus.wdata = 32'd0;
    bus.m_ack = 1'b0; bus.m_rdata = 32'd0;
    exp_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_mreq", 32'(bus.m_req), 32'd0);
    chk("rst_mwe", 32'(bus.m_we), 32'd0);
    chk("rst_mbe", 32'(bus.m_be), 32'd0);
    chk("rst_maddr", bus.m_addr, 32'd0);
    chk("rst_mwdata", bus.m_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'd0, 1'b0);
    chk("sw_be", 32'(cap_be), 32'hF);
    chk("sw_addr", cap_addr, 32'h100);
    chk("sw_done_cyc", 32'(cap_done_cyc), 32'd2);
    chk("sw_err", 32'(cap_err), 32'd0);

    run_txn(1'b0, 3'b000, 32'h203, 32'd0, 3, 32'h80FF1234, 1'b0);
    chk("lb_rdata", cap_rdata, 32'hFFFFFF80);
    chk("lb_done_cyc", 32'(cap_done_cyc), 32'd5);
    run_txn(1'b0, 3'b100, 32'h203, 32'd0, 3, 32'h80FF1234, 1'b0);
    chk("lbu_rdata", cap_rdata, 32'h00000080);

    run_txn(1'b1, 3'b001, 32'h22, 32'h0000ABCD, 1, 32'd0, 1'b0);
    chk("sh_be", 32'(cap_be), 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCDABCD);
    chk("sh_we", 32'(cap_we), 32'd1);

    run_txn(1'b0, 3'b010, 32'h300, 32'd0, TO, 32'd0, 1'b1);
    chk("to_done_cyc", 32'(cap_done_cyc), 32'(TO + 1));
    chk("to_err", 32'(cap_err), 32'd1);
    chk("to_rdata", cap_rdata, 32'd0);

    run_txn(1'b0, 3'b010, 32'h101, 32'd0, 0, 32'h1234_5678, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("lw_mis_done_cyc", 32'(cap_done_cyc), 32'd1);
    chk("lw_mis_err", 32'(cap_err), 32'd1);
`else
    chk("lw_mis_addr", cap_addr, 32'h100);
    chk("lw_mis_err", 32'(cap_err), 32'd0);
    chk("lw_mis_rdata", cap_rdata, 32'h1234_5678);
`endif

    run_txn(1'b0, 3'b011, 32'h40, 32'd0, 0, 32'd0, 1'b0);
    chk("ill_done_cyc", 32'(cap_done_cyc), 32'd1);
    chk("ill_err", 32'(cap_err), 32'd1);

    // Reset while waiting for an acknowledge that never comes
    bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    chk("rstw_mreq_before", 32'(bus.m_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_mreq", 32'(bus.m_req), 32'd0);
    chk("rstw_busy", 32'(bus.busy), 32'd0);
    chk("rstw_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    exp_rdata = 32'd0;
    @(negedge clk);
    chk("rstw_done_after", 32'(bus.done), 32'd0);

    for (int n = 0; n < 200; n++) begin
      run_txn(1'($urandom), 3'($urandom), $urandom, $urandom,
              int'($urandom_range(0, TO + 1)), $urandom, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
